// File: rtl/mult_div_part_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// The decode stage and hazard unit use the same MDSel encodings,
// so they live here rather than in the unit itself.
package mult_div_part_pkg;

  // MDSel encodings. Values 7-15 are unused and decode as "no operation".
  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6
  } md_sel_e;

  // Default latencies, in clock cycles from the launch edge to the write edge.
  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mult_div_part.sv
// Multiply/divide unit with architectural HI/LO registers.
//
// A Start pulse with MDSel = MULT/MULTU/DIV/DIVU latches the operands, raises
// Busy and loads a down-counter. When the counter reaches terminal count
// (value 1 at an edge), that edge writes HI/LO and drops Busy. MTHI/MTLO
// write HI/LO at the Start edge itself. Starts seen while Busy are ignored.
//
// Ports:
//   CLK          system clock, rising edge
//   Reset        asynchronous, active-high reset
//   Start        launch pulse, sampled at the rising edge
//   ALUOprand_A  operand A: rs / dividend / mthi-mtlo source
//   ALUOprand_B  operand B: rt / divisor
//   MDSel        operation select (see mult_div_part_pkg)
//   HI, LO       architectural HI/LO registers
//   Busy         high while a multiply or divide is in flight
//
// State table:
//   state   | meaning
//   ST_IDLE | no operation in flight; Start is accepted
//   ST_RUN  | mult/div in flight; counter running, Start ignored
module mult_div_part
  import mult_div_part_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] ALUOprand_A,
  input  logic [31:0] ALUOprand_B,
  input  logic [3:0]  MDSel,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC    = CNT_W'(1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q;
  logic [31:0]      op_a_q, op_b_q;
  logic [31:0]      hi_d, lo_d;
  logic             latch_en;

  // Results are computed combinationally from the latched operands; only the
  // write edge is timed by the counter.
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic [31:0] div_b, abs_a, abs_b, q_mag, r_mag;
  logic [31:0] quot_s, rem_s, quot_u, rem_u;
  logic        div_by_zero;

  always_comb begin
    a_sx   = {{32{op_a_q[31]}}, op_a_q};
    b_sx   = {{32{op_b_q[31]}}, op_b_q};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, op_a_q} * {32'd0, op_b_q};

    // Keep the dividers away from a zero divisor; the result is discarded then.
    div_by_zero = (op_b_q == 32'd0);
    div_b       = div_by_zero ? 32'd1 : op_b_q;
    quot_u      = op_a_q / div_b;
    rem_u       = op_a_q % div_b;

    // Signed divide on magnitudes: truncation toward zero falls out naturally,
    // and 0x80000000 / -1 yields quotient 0x80000000, remainder 0.
    abs_a  = op_a_q[31] ? (~op_a_q + 32'd1) : op_a_q;
    abs_b  = div_b[31]  ? (~div_b  + 32'd1) : div_b;
    q_mag  = abs_a / abs_b;
    r_mag  = abs_a % abs_b;
    quot_s = (op_a_q[31] ^ div_b[31]) ? (~q_mag + 32'd1) : q_mag;
    rem_s  = op_a_q[31] ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    hi_d     = HI;
    lo_d     = LO;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          case (MDSel)
            MD_MULT, MD_MULTU: begin
              latch_en = 1'b1;
              cnt_d    = MULT_LOAD;
              state_d  = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              latch_en = 1'b1;
              cnt_d    = DIV_LOAD;
              state_d  = ST_RUN;
            end
            MD_MTHI: hi_d = ALUOprand_A;
            MD_MTLO: lo_d = ALUOprand_A;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_TC) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          case (op_q)
            MD_MULT:  {hi_d, lo_d} = prod_s;
            MD_MULTU: {hi_d, lo_d} = prod_u;
            MD_DIV: begin
              if (!div_by_zero) begin
                hi_d = rem_s;
                lo_d = quot_s;
              end
            end
            MD_DIVU: begin
              if (!div_by_zero) begin
                hi_d = rem_u;
                lo_d = quot_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_TC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      HI      <= hi_d;
      LO      <= lo_d;
      if (latch_en) begin
        op_q   <= MDSel;
        op_a_q <= ALUOprand_A;
        op_b_q <= ALUOprand_B;
      end
    end
  end

  // state_q is a single flop, so Busy is a registered output.
  assign Busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_mult_div_part.sv
module tb_mult_div_part;
  import mult_div_part_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic [31:0] ALUOprand_A, ALUOprand_B;
  logic [3:0]  MDSel;
  logic [31:0] HI, LO;
  logic        Busy;

  int total  = 0;
  int passed = 0;

  // Reference architectural state.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mult_div_part #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start),
    .ALUOprand_A(ALUOprand_A), .ALUOprand_B(ALUOprand_B), .MDSel(MDSel),
    .HI(HI), .LO(LO), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Architectural effect of an accepted operation, straight from the ISA rules.
  task automatic model(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint      ps, q, r;
    logic [63:0] pu;
    case (sel)
      4'd1: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        m_hi = ps[63:32];
        m_lo = ps[31:0];
      end
      4'd2: begin
        pu = 64'(a) * 64'(b);
        m_hi = pu[63:32];
        m_lo = pu[31:0];
      end
      4'd3: if (b != 0) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      4'd4: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one Start and follow it to completion. inj_k > 0 fires an extra
  // MULT 3x3 Start at edge E0+inj_k, which must be ignored.
  task automatic do_op(input string tag, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input int inj_k);
    logic [31:0] old_hi, old_lo;
    int n;
    @(negedge CLK);
    Start = 1'b1; MDSel = sel; ALUOprand_A = a; ALUOprand_B = b;
    @(negedge CLK);
    // After E0: scramble don't-care inputs to prove operands were latched.
    Start = 1'b0; MDSel = 4'($urandom); ALUOprand_A = $urandom; ALUOprand_B = $urandom;
    old_hi = m_hi; old_lo = m_lo;
    model(sel, a, b);
    if (!(sel inside {4'd1, 4'd2, 4'd3, 4'd4})) begin
      chk({tag, ".busy"}, {31'd0, Busy}, 32'd0);
      chk({tag, ".hi"}, HI, m_hi);
      chk({tag, ".lo"}, LO, m_lo);
      return;
    end
    n = (sel <= 4'd2) ? 5 : 10;
    chk({tag, ".busy0"}, {31'd0, Busy}, 32'd1);
    chk({tag, ".hi0"}, HI, old_hi);
    for (int k = 1; k <= n; k++) begin
      if (k == inj_k) begin
        Start = 1'b1; MDSel = MD_MULT; ALUOprand_A = 32'd3; ALUOprand_B = 32'd3;
      end
      @(negedge CLK);
      Start = 1'b0;
      chk($sformatf("%s.busy%0d", tag, k), {31'd0, Busy}, (k < n) ? 32'd1 : 32'd0);
      chk($sformatf("%s.hi%0d", tag, k), HI, (k < n) ? old_hi : m_hi);
      chk($sformatf("%s.lo%0d", tag, k), LO, (k < n) ? old_lo : m_lo);
    end
    // One more idle cycle: nothing may launch or change.
    @(negedge CLK);
    chk({tag, ".idle_busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, ".idle_hi"}, HI, m_hi);
  endtask

  initial begin
    logic [3:0]  rs;
    logic [31:0] ra, rb;

    Reset = 1'b1; Start = 1'b0; MDSel = 4'd0; ALUOprand_A = '0; ALUOprand_B = '0;
    repeat (2) @(negedge CLK);
    chk("rst.hi", HI, 32'd0);
    chk("rst.lo", LO, 32'd0);
    chk("rst.busy", {31'd0, Busy}, 32'd0);
    Reset = 1'b0;

    do_op("mult25x2500", 4'd1, 32'd25, 32'd2500, 0);
    chk("mult25x2500.lo_const", LO, 32'h0000F424);
    do_op("mult_m1x2", 4'd1, 32'hFFFFFFFF, 32'd2, 0);
    do_op("multu_m1x2", 4'd2, 32'hFFFFFFFF, 32'd2, 0);
    chk("multu.hi_const", HI, 32'h00000001);
    do_op("div_m7_2", 4'd3, 32'hFFFFFFF9, 32'd2, 0);
    chk("div.lo_const", LO, 32'hFFFFFFFD);
    chk("div.hi_const", HI, 32'hFFFFFFFF);
    do_op("divu_7_2", 4'd4, 32'd7, 32'd2, 0);
    do_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("div_ovf.lo", LO, 32'h80000000);
    do_op("mthi", 4'd5, 32'h1234, 32'd0, 0);
    do_op("mtlo", 4'd6, 32'h5678, 32'd0, 0);
    do_op("div_by0", 4'd3, 32'd99, 32'd0, 0);
    chk("div_by0.hi_const", HI, 32'h1234);
    chk("div_by0.lo_const", LO, 32'h5678);
    do_op("divu_by0", 4'd4, 32'd99, 32'd0, 0);
    do_op("div_busy_start", 4'd3, 32'd100, 32'd7, 3);
    do_op("none7", 4'd7, 32'hDEAD, 32'd1, 0);
    do_op("none0", 4'd0, 32'hBEEF, 32'd1, 0);

    for (int i = 0; i < 30; i++) begin
      rs = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 100)) | {$urandom_range(0, 1) == 1, 31'd0};
      do_op($sformatf("rnd%0d", i), rs, ra, rb, (i % 4 == 0) ? 2 : 0);
    end

    // Reset mid-multiply: clears immediately and no late write follows.
    do_op("pre_rst_mthi", 4'd5, 32'hCAFE0001, 32'd0, 0);
    @(negedge CLK);
    Start = 1'b1; MDSel = MD_MULT; ALUOprand_A = 32'd5; ALUOprand_B = 32'd5;
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    #1 Reset = 1'b1;
    #1;
    chk("rst_mid.hi", HI, 32'd0);
    chk("rst_mid.lo", LO, 32'd0);
    chk("rst_mid.busy", {31'd0, Busy}, 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (8) @(negedge CLK);
    chk("rst_after.hi", HI, m_hi);
    chk("rst_after.lo", LO, m_lo);
    chk("rst_after.busy", {31'd0, Busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
